// File: rtl/jtag_fifo_mailbox_if.sv
// Fabric-side stream bundle of the JTAG mailbox: RX (host->fabric) and TX (fabric->host).
interface jtag_fifo_mailbox_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  // master = fabric logic, slave = mailbox
  modport master (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );
  modport slave (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/jtag_fifo_mailbox.sv
// Virtual-JTAG mailbox in the tck domain: PUSH fills the RX FIFO, POP drains the TX FIFO,
// STATUS captures counts and sticky errors, CLEAR wipes the sticky errors.
module jtag_fifo_mailbox #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RX_DEPTH = 8,
  parameter int unsigned TX_DEPTH = 8,
  parameter int unsigned IR_W     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tdi_i,
  input  logic [IR_W-1:0]   ir_in_i,
  input  logic              vs_cdr_i,
  input  logic              vs_sdr_i,
  input  logic              vs_udr_i,
  output logic              tdo_o,
  jtag_fifo_mailbox_if.slave fab,
  output logic [7:0]        rx_count_o,
  output logic [7:0]        tx_count_o,
  output logic              overflow_o,
  output logic              underflow_o
);
  localparam int unsigned RX_AW = $clog2(RX_DEPTH);
  localparam int unsigned TX_AW = $clog2(TX_DEPTH);
  localparam int unsigned RX_CW = RX_AW + 1;
  localparam int unsigned TX_CW = TX_AW + 1;

  localparam logic [IR_W-1:0] IR_PUSH   = IR_W'(1);
  localparam logic [IR_W-1:0] IR_POP    = IR_W'(2);
  localparam logic [IR_W-1:0] IR_STATUS = IR_W'(3);
  localparam logic [IR_W-1:0] IR_CLEAR  = IR_W'(4);

  logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
  logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
  logic [RX_AW-1:0]  rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [TX_AW-1:0]  tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [RX_CW-1:0]  rx_cnt_q, rx_cnt_d;
  logic [TX_CW-1:0]  tx_cnt_q, tx_cnt_d;
  logic [DATA_W-1:0] sh_in_q, sh_in_d, sh_out_q, sh_out_d, sh_st_q, sh_st_d;
  logic              pop_pend_q, pop_pend_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;

  logic is_push, is_pop, is_status, is_clear;
  logic rx_full, tx_empty, rx_wr, rx_pop, tx_wr, tx_pop, ovf_ev, unf_ev;
  logic [DATA_W-1:0] status_word;

  assign is_push   = (ir_in_i == IR_PUSH);
  assign is_pop    = (ir_in_i == IR_POP);
  assign is_status = (ir_in_i == IR_STATUS);
  assign is_clear  = (ir_in_i == IR_CLEAR);

  // RX fullness is judged before any same-edge fabric pop
  assign rx_full  = (rx_cnt_q == RX_CW'(RX_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_pop   = fab.rx_valid & fab.rx_ready;
  assign rx_wr    = is_push & vs_udr_i & ~rx_full;
  assign ovf_ev   = is_push & vs_udr_i & rx_full;
  assign tx_pop   = is_pop & vs_udr_i & pop_pend_q;
  assign tx_wr    = fab.tx_valid & fab.tx_ready;
  assign unf_ev   = is_pop & vs_cdr_i & tx_empty;

  // A POP update frees a slot on the same edge, so a full TX can still accept
  assign fab.tx_ready = (tx_cnt_q != TX_CW'(TX_DEPTH)) | tx_pop;
  assign fab.rx_valid = (rx_cnt_q != '0);
  assign fab.rx_data  = rx_mem_q[rx_rp_q];
  assign rx_count_o   = 8'(rx_cnt_q);
  assign tx_count_o   = 8'(tx_cnt_q);
  assign overflow_o   = ovf_q;
  assign underflow_o  = unf_q;

  always_comb begin
    status_word           = '0;
    status_word[7:0]      = 8'(rx_cnt_q);
    status_word[15:8]     = 8'(tx_cnt_q);
    status_word[DATA_W-2] = unf_q;
    status_word[DATA_W-1] = ovf_q;
  end

  always_comb begin
    case (1'b1)
      is_push:   tdo_o = sh_in_q[0];
      is_pop:    tdo_o = sh_out_q[0];
      is_status: tdo_o = sh_st_q[0];
      default:   tdo_o = tdi_i;
    endcase
  end

  always_comb begin
    rx_wp_d    = rx_wp_q;
    rx_rp_d    = rx_rp_q;
    tx_wp_d    = tx_wp_q;
    tx_rp_d    = tx_rp_q;
    rx_cnt_d   = rx_cnt_q + RX_CW'(rx_wr) - RX_CW'(rx_pop);
    tx_cnt_d   = tx_cnt_q + TX_CW'(tx_wr) - TX_CW'(tx_pop);
    sh_in_d    = sh_in_q;
    sh_out_d   = sh_out_q;
    sh_st_d    = sh_st_q;
    pop_pend_d = pop_pend_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;

    if (rx_wr)  rx_wp_d = rx_wp_q + RX_AW'(1);
    if (rx_pop) rx_rp_d = rx_rp_q + RX_AW'(1);
    if (tx_wr)  tx_wp_d = tx_wp_q + TX_AW'(1);
    if (tx_pop) begin
      tx_rp_d    = tx_rp_q + TX_AW'(1);
      pop_pend_d = 1'b0;
    end

    if (is_push && vs_sdr_i) sh_in_d = {tdi_i, sh_in_q[DATA_W-1:1]};

    if (is_pop && vs_cdr_i) begin
      sh_out_d   = tx_empty ? '0 : tx_mem_q[tx_rp_q];
      pop_pend_d = ~tx_empty;
    end else if (is_pop && vs_sdr_i) begin
      sh_out_d = {tdi_i, sh_out_q[DATA_W-1:1]};
    end

    if (is_status && vs_cdr_i)      sh_st_d = status_word;
    else if (is_status && vs_sdr_i) sh_st_d = {tdi_i, sh_st_q[DATA_W-1:1]};

    // Clear first so a coincident error event wins
    if (is_clear && vs_udr_i) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (ovf_ev) ovf_d = 1'b1;
    if (unf_ev) unf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      rx_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      sh_in_q    <= '0;
      sh_out_q   <= '0;
      sh_st_q    <= '0;
      pop_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      tx_wp_q    <= tx_wp_d;
      tx_rp_q    <= tx_rp_d;
      rx_cnt_q   <= rx_cnt_d;
      tx_cnt_q   <= tx_cnt_d;
      sh_in_q    <= sh_in_d;
      sh_out_q   <= sh_out_d;
      sh_st_q    <= sh_st_d;
      pop_pend_q <= pop_pend_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // Storage arrays carry no reset; occupancy counts gate every read
  always_ff @(posedge clk) begin
    if (!reset && rx_wr) rx_mem_q[rx_wp_q] <= sh_in_q;
    if (!reset && tx_wr) tx_mem_q[tx_wp_q] <= fab.tx_data;
  end
endmodule
